stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Multi-cycle control FSM for the simple processor. It sequences each instruction through the FETCH, DECODE, EXEC, MEM and WB stages, and issues one-cycle enables to imem, regfile, ALU, dmem and PC. It holds in MEM until dmem acknowledges, with a bounded timeout. It sits between the top-level skeleton clock/reset and the datapath, and replaces free-running per-unit clocks with explicit stage enables.

Parameters:
MEM_TIMEOUT, 16, maximum MEM cycles without dmem_ready before FAULT (legal range 1..255).
CNT_WIDTH, 32, width of the performance counters.

Ports:
clock  in  1  system clock; all state updates on posedge.
ctrl_reset  in  1  synchronous active-high reset.
run  in  1  level; leaving IDLE requires run=1.
halt_req  in  1  level; sampled only at instruction boundary.
opcode  in  5  q_imem[31:27], valid in DECODE.
dmem_ready  in  1  dmem acknowledge for the current MEM access.
imem_en  out  1  fetch strobe.
regfile_re  out  1  register read strobe.
alu_en  out  1  execute strobe.
dmem_en  out  1  dmem access request.
dmem_we  out  1  store qualifier, valid with dmem_en.
ctrl_writeEnable  out  1  regfile write strobe.
pc_en  out  1  PC update strobe, final cycle of each instruction.
busy  out  1  high in any state other than IDLE and FAULT.
fault  out  1  sticky MEM timeout flag.
retired_count  out  CNT_WIDTH  instructions retired (optional feature).
stall_count  out  CNT_WIDTH  MEM cycles with dmem_ready=0 (optional feature).

Behaviour:
- Clock is `clock`. Reset is `ctrl_reset`, synchronous and active-high. No asynchronous reset paths.
- Reset, including mid-instruction: the next posedge enters IDLE. All outputs go to 0, counters clear, fault clears, and the latched opcode becomes 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- Instruction classes are decoded from the opcode latched at the DECODE edge:
  - ALU (00000, 00101 addi, 10101 setx): F D E W, 4 cycles.
  - LOAD (01000 lw): F D E M+ W.
  - STORE (00111 sw): F D E M+.
  - CTRL (00001 j, 00010 bne, 00100 jr, 00110 blt, 10110 bex): F D E, 3 cycles.
  - LINK (00011 jal): F D E W.
  - Any other opcode: treated as CTRL, i.e. a no-op with no write.
- Strobes are Moore outputs, one state each:
  - imem_en=1 in FETCH.
  - regfile_re=1 in DECODE.
  - alu_en=1 in EXEC.
  - dmem_en=1 in every MEM cycle; dmem_we=1 with it for STORE only.
  - ctrl_writeEnable=1 in WB.
- pc_en=1 in the last stage of an instruction: EXEC for CTRL, MEM on the exit cycle for STORE, WB for ALU/LOAD/LINK.
- IDLE->FETCH when run=1.
- At the boundary (the cycle with pc_en=1): if halt_req=1 or run=0, the next state is IDLE; otherwise it is FETCH.
- MEM exits at the posedge where dmem_ready=1, so it lasts 1 cycle if dmem_ready is already high on entry. On exit it goes to WB for LOAD, or to the boundary for STORE.
- MEM wait counter: 8-bit, cleared on MEM entry, incremented each MEM cycle with dmem_ready=0. When the count reaches MEM_TIMEOUT with dmem_ready still 0, the next state is FAULT.
- FAULT:
  - fault=1, busy=0, all strobes 0.
  - Held until ctrl_reset; run is ignored.
  - The faulting instruction gets no pc_en and does not retire.
- dmem_ready outside MEM is ignored.
- halt_req in mid-instruction has no effect until the boundary.

Optional Feature:
STAGE_SEQ_PERF_COUNTERS_EN.
- Defined: retired_count increments on every pc_en cycle. stall_count increments on every MEM cycle with dmem_ready=0. Both wrap modulo 2^CNT_WIDTH and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.
- Port list is identical either way.

Decomposition:
- Package stage_seq_pkg holds:
  - state enum (7 states, 3-bit encoding).
  - opcode constants (5-bit).
  - instruction-class enum (ALU, LOAD, STORE, CTRL, LINK).
- One natural sub-module: stage_seq_decode, a combinational opcode-to-class decoder. It is reusable by the datapath's control-signal decoder.

Test Plan:
- Reset then run=1 with opcode=00000 (add): imem_en, regfile_re, alu_en, ctrl_writeEnable on cycles 1-4; pc_en on cycle 4; next FETCH on cycle 5.
- lw (01000) with dmem_ready low for 3 MEM cycles, then high: MEM lasts 4 cycles, then WB; total 8 cycles; stall_count=3 (feature on).
- sw (00111) with dmem_ready already high: dmem_en=dmem_we=1 for exactly 1 cycle; pc_en in that cycle; ctrl_writeEnable never asserts.
- lw with dmem_ready held low and MEM_TIMEOUT=4: fault=1 after the 4th stalled MEM cycle; busy=0; no pc_en. run toggling has no effect; ctrl_reset clears fault.
- halt_req raised during EXEC of addi (00101): WB and pc_en still complete, then IDLE with busy=0. ctrl_reset asserted in a later MEM cycle of lw: IDLE next cycle, all outputs 0.
- 5 back-to-back mixed instructions (add, addi, sw, j, lw): retired_count=5 with the feature on; retired_count=0 with STAGE_SEQ_PERF_COUNTERS_EN undefined.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared definitions for the multi-cycle stage sequencer.
// Holds the sequencer state encoding, the 5-bit opcode constants taken from
// q_imem[31:27], and the instruction-class encoding produced by the opcode
// decoder and consumed by the sequencer and the datapath control decoder.
package stage_seq_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  // Instruction classes; each class fixes the stage path of an instruction
  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_CTRL  = 3'd3,
    CLS_LINK  = 3'd4
  } instr_class_t;

endpackage

// File: rtl/stage_seq_decode.sv
// Combinational opcode-to-class decoder.
// Ports:
//   opcode     in  5  instruction opcode (q_imem[31:27])
//   instrClass out 3  instr_class_t encoding of the instruction class
// Unknown opcodes decode as CTRL so they run as a no-op without a write.
module stage_seq_decode
  import stage_seq_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [2:0] instrClass
);

  // Opcode lookup
  always_comb begin
    instrClass = CLS_CTRL;
    case (opcode)
      OP_ADD, OP_ADDI, OP_SETX:             instrClass = CLS_ALU;
      OP_LW:                                instrClass = CLS_LOAD;
      OP_SW:                                instrClass = CLS_STORE;
      OP_JAL:                               instrClass = CLS_LINK;
      OP_J, OP_BNE, OP_JR, OP_BLT, OP_BEX:  instrClass = CLS_CTRL;
      default:                              instrClass = CLS_CTRL;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB and issues one-cycle stage enables to the datapath.
// MEM holds until dmem_ready, bounded by MEM_TIMEOUT stalled cycles, after
// which the sequencer parks in FAULT until ctrl_reset.
// Optional feature macro: STAGE_SEQ_PERF_COUNTERS_EN (retired/stall counters;
// when undefined the counter outputs are tied to zero).
// Ports:
//   clock, ctrl_reset          clock and synchronous active-high reset
//   run, halt_req              start level / stop request at the boundary
//   opcode                     opcode, valid in DECODE
//   dmem_ready                 dmem acknowledge for the current MEM access
//   imem_en, regfile_re, alu_en, dmem_en, dmem_we, ctrl_writeEnable
//                              per-stage strobes
//   pc_en                      final cycle of each instruction
//   busy, fault                status
//   retired_count, stall_count performance counters
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic [4:0]           opcode,
  input  logic                 dmem_ready,
  output logic                 imem_en,
  output logic                 regfile_re,
  output logic                 alu_en,
  output logic                 dmem_en,
  output logic                 dmem_we,
  output logic                 ctrl_writeEnable,
  output logic                 pc_en,
  output logic                 busy,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  // Wait count at which one more stalled cycle means timeout
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_r;
  state_t     nextState_s;
  state_t     boundaryNext_s;
  logic [4:0] opcode_r;
  logic [4:0] decodeOpcode_s;
  logic [2:0] class_s;
  logic [7:0] memWait_r;
  logic       pcEnReg_r;

  // In DECODE the opcode is being latched this edge, so decode the live
  // input; afterwards decode the latched copy.
  assign decodeOpcode_s = (state_r == ST_DECODE) ? opcode : opcode_r;

  stage_seq_decode uDecode (
    .opcode     (decodeOpcode_s),
    .instrClass (class_s)
  );

  // Where the sequencer goes after the last stage of an instruction
  always_comb begin
    if (halt_req || !run) begin
      boundaryNext_s = ST_IDLE;
    end else begin
      boundaryNext_s = ST_FETCH;
    end
  end

  // Next-state selection
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          nextState_s = ST_FETCH;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_FETCH:  nextState_s = ST_DECODE;
      ST_DECODE: nextState_s = ST_EXEC;
      ST_EXEC: begin
        case (class_s)
          CLS_CTRL:            nextState_s = boundaryNext_s;
          CLS_LOAD, CLS_STORE: nextState_s = ST_MEM;
          default:             nextState_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (class_s == CLS_STORE) begin
            nextState_s = boundaryNext_s;
          end else begin
            nextState_s = ST_WB;
          end
        end else if (memWait_r == TIMEOUT_LAST) begin
          nextState_s = ST_FAULT;
        end else begin
          nextState_s = ST_MEM;
        end
      end
      ST_WB:    nextState_s = boundaryNext_s;
      ST_FAULT: nextState_s = ST_FAULT;
      default:  nextState_s = ST_IDLE;
    endcase
  end

  // State, opcode latch, MEM wait counter and registered stage strobes.
  // Strobes are registered from the next state so each one is high for
  // exactly the cycle the FSM spends in its stage.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_r          <= ST_IDLE;
      opcode_r         <= 5'd0;
      memWait_r        <= 8'd0;
      imem_en          <= 1'b0;
      regfile_re       <= 1'b0;
      alu_en           <= 1'b0;
      dmem_en          <= 1'b0;
      dmem_we          <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      pcEnReg_r        <= 1'b0;
      busy             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state_r <= nextState_s;
      if (state_r == ST_DECODE) begin
        opcode_r <= opcode;
      end
      // Counts stalled cycles of the current access; zero outside MEM
      if (state_r != ST_MEM) begin
        memWait_r <= 8'd0;
      end else if (!dmem_ready) begin
        memWait_r <= memWait_r + 8'd1;
      end
      imem_en          <= (nextState_s == ST_FETCH);
      regfile_re       <= (nextState_s == ST_DECODE);
      alu_en           <= (nextState_s == ST_EXEC);
      dmem_en          <= (nextState_s == ST_MEM);
      dmem_we          <= (nextState_s == ST_MEM) && (class_s == CLS_STORE);
      ctrl_writeEnable <= (nextState_s == ST_WB);
      pcEnReg_r        <= (nextState_s == ST_WB) ||
                          ((nextState_s == ST_EXEC) && (class_s == CLS_CTRL));
      busy             <= (nextState_s != ST_IDLE) && (nextState_s != ST_FAULT);
      fault            <= (nextState_s == ST_FAULT);
    end
  end

  // A store retires on the MEM cycle that dmem acknowledges, which cannot be
  // known a cycle ahead, so that term is qualified by the live dmem_ready.
  assign pc_en = pcEnReg_r | (dmem_we & dmem_ready);

`ifdef STAGE_SEQ_PERF_COUNTERS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] retiredCount_r;
  logic [CNT_WIDTH-1:0] stallCount_r;

  // Retired-instruction and MEM-stall counters, wrapping
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      retiredCount_r <= {CNT_WIDTH{1'b0}};
      stallCount_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      if (pc_en) begin
        retiredCount_r <= retiredCount_r + CNT_ONE;
      end
      if ((state_r == ST_MEM) && !dmem_ready) begin
        stallCount_r <= stallCount_r + CNT_ONE;
      end
    end
  end

  assign retired_count = retiredCount_r;
  assign stall_count   = stallCount_r;
`else
  assign retired_count = {CNT_WIDTH{1'b0}};
  assign stall_count   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. A cycle table is built up front
// from instruction-level descriptions (class path, stall count, stop mode),
// first with directed corner sequences and then random instructions; each
// record carries the inputs for one cycle and the outputs expected in it.
module tb_stage_sequencer;

  localparam int TB_TIMEOUT = 4;
  localparam int CW         = 32;

  // Stage tags of the expected trace
  localparam int S_IDLE  = 0;
  localparam int S_F     = 1;
  localparam int S_D     = 2;
  localparam int S_E     = 3;
  localparam int S_M     = 4;
  localparam int S_W     = 5;
  localparam int S_FAULT = 6;

  // Instruction classes
  localparam int C_ALU   = 0;
  localparam int C_LOAD  = 1;
  localparam int C_STORE = 2;
  localparam int C_CTRL  = 3;
  localparam int C_LINK  = 4;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          run;
  logic          halt_req;
  logic [4:0]    opcode;
  logic          dmem_ready;
  logic          imem_en, regfile_re, alu_en, dmem_en, dmem_we;
  logic          ctrl_writeEnable, pc_en, busy, fault;
  logic [CW-1:0] retired_count, stall_count;

  stage_sequencer #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(CW)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .run              (run),
    .halt_req         (halt_req),
    .opcode           (opcode),
    .dmem_ready       (dmem_ready),
    .imem_en          (imem_en),
    .regfile_re       (regfile_re),
    .alu_en           (alu_en),
    .dmem_en          (dmem_en),
    .dmem_we          (dmem_we),
    .ctrl_writeEnable (ctrl_writeEnable),
    .pc_en            (pc_en),
    .busy             (busy),
    .fault            (fault),
    .retired_count    (retired_count),
    .stall_count      (stall_count)
  );

  always #5 clock = ~clock;

  // exp = {imem, re, alu, dmem_en, dmem_we, we, pc, busy, fault}
  typedef struct {
    bit         rst;
    bit         run;
    bit         halt;
    logic [4:0] opc;
    bit         rdy;
    int         stage;
    bit         pc;
    logic [8:0] exp;
  } cyc_t;

  cyc_t trace[$];
  bit   atIdle      = 1'b1;
  int   nCompared   = 0;
  int   nMismatched = 0;

  function automatic int refClass(input logic [4:0] opc);
    case (opc)
      5'b00000, 5'b00101, 5'b10101: return C_ALU;
      5'b01000:                     return C_LOAD;
      5'b00111:                     return C_STORE;
      5'b00011:                     return C_LINK;
      default:                      return C_CTRL;
    endcase
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] ro();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic pushCyc(input int stage, input bit rst, input bit runV,
                         input bit haltV, input logic [4:0] opc, input bit rdy,
                         input bit store, input bit pc);
    cyc_t c;
    c.rst   = rst;
    c.run   = runV;
    c.halt  = haltV;
    c.opc   = opc;
    c.rdy   = rdy;
    c.stage = stage;
    c.pc    = pc;
    c.exp   = {stage == S_F, stage == S_D, stage == S_E, stage == S_M,
               (stage == S_M) && store, stage == S_W, pc,
               !(stage == S_IDLE || stage == S_FAULT), stage == S_FAULT};
    trace.push_back(c);
  endtask

  // Idle cycles with run low, then one with run high to start fetching
  task automatic leaveIdle(input int extra);
    for (int k = 0; k < extra; k++) pushCyc(S_IDLE, 0, 0, rb(), ro(), rb(), 0, 0);
    pushCyc(S_IDLE, 0, 1, rb(), ro(), rb(), 0, 0);
    atIdle = 1'b0;
  endtask

  // One instruction; stopMode bit0 = halt_req, bit1 = run low at the boundary
  task automatic instr(input logic [4:0] opc, input int stalls, input int stopMode);
    int cls;
    bit store, bRun, bHalt;
    cls   = refClass(opc);
    store = (cls == C_STORE);
    bRun  = !stopMode[1];
    bHalt = stopMode[0];
    if (atIdle) leaveIdle($urandom_range(0, 2));
    pushCyc(S_F, 0, rb(), rb(), ro(), rb(), 0, 0);
    pushCyc(S_D, 0, rb(), rb(), opc, rb(), 0, 0);
    if (cls == C_CTRL) pushCyc(S_E, 0, bRun, bHalt, ro(), rb(), 0, 1);
    else               pushCyc(S_E, 0, rb(), rb(), ro(), rb(), 0, 0);
    if (cls == C_LOAD || cls == C_STORE) begin
      for (int k = 0; k < stalls; k++) pushCyc(S_M, 0, rb(), rb(), ro(), 0, store, 0);
      if (store) pushCyc(S_M, 0, bRun, bHalt, ro(), 1, 1, 1);
      else       pushCyc(S_M, 0, rb(), rb(), ro(), 1, 0, 0);
    end
    if (cls != C_CTRL && cls != C_STORE) pushCyc(S_W, 0, bRun, bHalt, ro(), rb(), 0, 1);
    atIdle = (stopMode != 0);
  endtask

  // lw whose dmem never answers: timeout, FAULT with run toggling, reset
  task automatic faultSeq();
    if (atIdle) leaveIdle($urandom_range(0, 2));
    pushCyc(S_F, 0, rb(), rb(), ro(), rb(), 0, 0);
    pushCyc(S_D, 0, rb(), rb(), 5'b01000, rb(), 0, 0);
    pushCyc(S_E, 0, rb(), rb(), ro(), rb(), 0, 0);
    for (int k = 0; k < TB_TIMEOUT; k++) pushCyc(S_M, 0, rb(), rb(), ro(), 0, 0, 0);
    for (int k = 0; k < 4; k++) pushCyc(S_FAULT, 0, k[0], rb(), ro(), rb(), 0, 0);
    pushCyc(S_FAULT, 1, 1, 0, ro(), rb(), 0, 0);
    atIdle = 1'b1;
  endtask

  // lw reset in its second stalled MEM cycle
  task automatic midMemReset();
    if (atIdle) leaveIdle($urandom_range(0, 2));
    pushCyc(S_F, 0, rb(), rb(), ro(), rb(), 0, 0);
    pushCyc(S_D, 0, rb(), rb(), 5'b01000, rb(), 0, 0);
    pushCyc(S_E, 0, rb(), rb(), ro(), rb(), 0, 0);
    pushCyc(S_M, 0, rb(), rb(), ro(), 0, 0, 0);
    pushCyc(S_M, 1, rb(), rb(), ro(), 0, 0, 0);
    atIdle = 1'b1;
  endtask

  initial begin
    logic [CW-1:0] expRet, expStall;
    logic [CW-1:0] wantRet, wantStall;
    logic [8:0]    act;
    int            pick;

    ctrl_reset = 1'b1;
    run        = 1'b0;
    halt_req   = 1'b0;
    opcode     = 5'd0;
    dmem_ready = 1'b0;

    // Directed sequences
    leaveIdle(0);
    instr(5'b00000, 0, 0);   // add, then straight into the next fetch
    instr(5'b01000, 3, 0);   // lw with 3 stalled MEM cycles
    instr(5'b00111, 0, 0);   // sw acknowledged on entry
    instr(5'b00101, 0, 1);   // addi with halt at the boundary
    midMemReset();
    faultSeq();
    instr(5'b00000, 0, 0);   // five back to back after reset
    instr(5'b00101, 0, 0);
    instr(5'b00111, 1, 0);
    instr(5'b00001, 0, 0);
    instr(5'b01000, 0, 2);
    instr(5'b00011, 0, 3);   // jal, run low and halt at the boundary
    instr(5'b11111, 0, 0);   // unknown opcode behaves as a no-op

    // Random instructions
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 19);
      if (pick == 18)      midMemReset();
      else if (pick == 19) faultSeq();
      else instr(ro(), $urandom_range(0, TB_TIMEOUT - 1),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    repeat (2) @(posedge clock);
    expRet   = '0;
    expStall = '0;
    for (int i = 0; i < trace.size(); i++) begin
      @(posedge clock);
      #1;
      ctrl_reset = trace[i].rst;
      run        = trace[i].run;
      halt_req   = trace[i].halt;
      opcode     = trace[i].opc;
      dmem_ready = trace[i].rdy;
      @(negedge clock);

      act = {imem_en, regfile_re, alu_en, dmem_en, dmem_we, ctrl_writeEnable,
             pc_en, busy, fault};
      nCompared++;
      if (act !== trace[i].exp) begin
        nMismatched++;
        $display("FAIL cycle %0d outputs {imem,re,alu,den,dwe,we,pc,busy,fault}: got %b expected %b",
                 i, act, trace[i].exp);
      end

`ifdef STAGE_SEQ_PERF_COUNTERS_EN
      wantRet   = expRet;
      wantStall = expStall;
`else
      wantRet   = '0;
      wantStall = '0;
`endif
      nCompared++;
      if (retired_count !== wantRet || stall_count !== wantStall) begin
        nMismatched++;
        $display("FAIL cycle %0d counters: got retired=%0d stall=%0d expected retired=%0d stall=%0d",
                 i, retired_count, stall_count, wantRet, wantStall);
      end

      if (trace[i].rst) begin
        expRet   = '0;
        expStall = '0;
      end else begin
        expRet   = expRet + CW'(trace[i].pc);
        expStall = expStall + CW'((trace[i].stage == S_M) && !trace[i].rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
